// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared definitions for the sram-like bridge and adapters: FSM states, size codes,
// AXI ID/burst constants and the write-strobe helper.
package sram_like_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic       PORT_INST  = 1'b0;
  localparam logic       PORT_DATA  = 1'b1;
  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;

  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sram_like_arbiter.sv
// Fixed-priority grant (data over inst) and request latch; addr_ok is combinational
// from req while the bridge is idle, so a non-idle bridge simply holds off both masters.
module sram_like_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        idle,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        inst_addr_ok,
  output logic        data_addr_ok,
  output logic        grant,
  output logic        grant_wr,
  output logic        req_port,
  output logic        req_wr,
  output logic [1:0]  req_size,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata
);
  import sram_like_axi_bridge_pkg::*;

  logic        port_q, port_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  always_comb begin
    data_addr_ok = idle && data_req;
    inst_addr_ok = idle && inst_req && !data_req;
    grant        = data_addr_ok || inst_addr_ok;
    grant_wr     = data_req ? data_wr : inst_wr;
    port_d  = port_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (data_addr_ok) begin
      port_d  = PORT_DATA;
      wr_d    = data_wr;
      size_d  = data_size;
      addr_d  = data_addr;
      wdata_d = data_wdata;
    end else if (inst_addr_ok) begin
      port_d  = PORT_INST;
      wr_d    = inst_wr;
      size_d  = inst_size;
      addr_d  = inst_addr;
      wdata_d = inst_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      port_q  <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      port_q  <= port_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_port  = port_q;
  assign req_wr    = wr_q;
  assign req_size  = size_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;

endmodule

// File: rtl/sram_like_axi_bridge.sv
// Two sram-like slave ports to one AXI3 master, one transaction in flight; data_ok two
// cycles after addr_ok at best, AXI valids and payload held until their ready.
module sram_like_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  import sram_like_axi_bridge_pkg::*;

  state_e      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        idle, grant, grant_wr, done;
  logic        req_port, req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_id;
  logic        unused_ok;

  // Gated by resetn so no addr_ok escapes while reset is held.
  assign idle = (state_q == IDLE) && resetn;

  sram_like_arbiter u_arb (
    .clk(clk), .resetn(resetn), .idle(idle),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .inst_addr_ok(inst_addr_ok), .data_addr_ok(data_addr_ok),
    .grant(grant), .grant_wr(grant_wr),
    .req_port(req_port), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata)
  );

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (grant) state_d = grant_wr ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      WR_ADDR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (awready) aw_done_d = 1'b1;
        if (wready)  w_done_d  = 1'b1;
        if ((aw_done_q || awready) && (w_done_q || wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign inst_data_ok = done && (req_port == PORT_INST);
  assign data_data_ok = done && (req_port == PORT_DATA);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign req_id  = (req_port == PORT_DATA) ? ID_DATA : ID_INST;
  assign arid    = req_id;
  assign araddr  = req_addr;
  assign arsize  = {1'b0, req_size};
  assign arlen   = 8'd0;
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = req_id;
  assign awaddr  = req_addr;
  assign awsize  = {1'b0, req_size};
  assign awlen   = 8'd0;
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = req_id;
  assign wdata   = req_wdata;
  assign wstrb   = size_to_wstrb(req_size, req_addr[1:0]);
  assign wlast   = 1'b1;

  // Single-beat, non-pipelined: response IDs/status and rlast carry no extra information.
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp, req_wr};

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Directed-vector bench for sram_like_axi_bridge: inputs change 1ns after posedge,
// outputs are checked 2ns later, well clear of the next edge.
module tb_sram_like_axi_bridge;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [8:0]  hs;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sram_like_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  assign hs = {arvalid, rready, awvalid, wvalid, bready,
               inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic port, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
    end
  endtask

  typedef struct {
    logic        port;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
  } wvec_t;

  wvec_t wv [4];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wv[0] = '{1'b1, 2'd1, 32'h8000_0002, 32'h1234_0000, 4'b1100};
    wv[1] = '{1'b0, 2'd2, 32'h0000_0010, 32'hCAFE_F00D, 4'b1111};
    wv[2] = '{1'b1, 2'd0, 32'h8000_0001, 32'h0000_5A00, 4'b0010};
    wv[3] = '{1'b1, 2'd1, 32'h8000_0000, 32'h0000_BEEF, 4'b0011};

    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; bid = 0; bresp = 0;

    // Reset: everything quiet, even with a request pending
    inst_req = 1'b1;
    #2;
    check("rst_handshakes", 32'(hs), 32'h0);
    check("rst_consts", {arlen, awlen, arburst, awburst, arlock, awlock, 4'h0},
          {8'h00, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 4'h0});
    check("rst_cache_prot", {arcache, awcache, arprot, awprot}, 14'h0);
    inst_req = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    cyc();

    // 1: minimum-latency inst read
    drive_req(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
    #2;
    check("t1_c0_addr_ok", {inst_addr_ok, data_addr_ok, arvalid}, 3'b100);
    cyc(); inst_req = 0; arready = 1;
    #2;
    check("t1_c1_arvalid", arvalid, 1'b1);
    check("t1_c1_araddr", araddr, 32'hBFC0_0000);
    check("t1_c1_arid_size", {arid, 1'b0, arsize}, {4'd0, 1'b0, 3'd2});
    check("t1_c1_no_dok", inst_data_ok, 1'b0);
    cyc(); arready = 0; rvalid = 1; rdata = 32'h3C08_0001;
    #2;
    check("t1_c2_dok", {rready, inst_data_ok, data_data_ok, arvalid}, 4'b1100);
    check("t1_c2_rdata", inst_rdata, 32'h3C08_0001);
    cyc(); rvalid = 0;
    #2;
    check("t1_c3_idle", 32'(hs), 32'h0);

    // 2: simultaneous requests, data wins, inst granted after data_ok
    drive_req(1'b1, 1'b0, 2'd2, 32'h8000_1000, 32'h0);
    drive_req(1'b0, 1'b0, 2'd2, 32'h1FC0_0004, 32'h0);
    #2;
    check("t2_grant", {data_addr_ok, inst_addr_ok}, 2'b10);
    cyc(); data_req = 0; arready = 1;
    #2;
    check("t2_ar", {arid, araddr}, {4'd1, 32'h8000_1000});
    check("t2_inst_held_ar", inst_addr_ok, 1'b0);
    cyc(); arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
    #2;
    check("t2_dok", {data_data_ok, inst_data_ok, inst_addr_ok}, 3'b100);
    check("t2_rdata", data_rdata, 32'hDEAD_BEEF);
    cyc(); rvalid = 0;
    #2;
    check("t2_inst_grant", {inst_addr_ok, data_addr_ok}, 2'b10);
    cyc(); inst_req = 0; arready = 1;
    #2;
    check("t2_inst_ar", {arid, araddr}, {4'd0, 32'h1FC0_0004});
    cyc(); arready = 0; rvalid = 1; rdata = 32'h0000_0042;
    #2;
    check("t2_inst_dok", {inst_data_ok, data_data_ok}, 2'b10);
    check("t2_inst_rdata", inst_rdata, 32'h0000_0042);
    cyc(); rvalid = 0;

    // 3: byte write with split aw/w handshakes
    drive_req(1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000);
    #2;
    check("t3_c0_addr_ok", data_addr_ok, 1'b1);
    cyc(); data_req = 0; awready = 1;
    #2;
    check("t3_c1_valids", {awvalid, wvalid, wlast}, 3'b111);
    check("t3_c1_aw", {awid, awaddr, 1'b0, awsize}, {4'd1, 32'h8000_0003, 1'b0, 3'd0});
    check("t3_c1_w", {wid, wstrb, wdata}, {4'd1, 4'b1000, 32'hAB00_0000});
    cyc(); awready = 0;
    #2;
    check("t3_c2", {awvalid, wvalid, bready, data_data_ok}, 4'b0100);
    cyc(); wready = 1;
    #2;
    check("t3_c3", {awvalid, wvalid, wstrb}, {2'b01, 4'b1000});
    cyc(); wready = 0;
    #2;
    check("t3_c4", {awvalid, wvalid, bready, data_data_ok}, 4'b0010);
    cyc(); bvalid = 1;
    #2;
    check("t3_c5", {bready, data_data_ok, inst_data_ok}, 3'b110);
    cyc(); bvalid = 0;
    #2;
    check("t3_c6", 32'(hs), 32'h0);

    // 4: minimum-latency writes across sizes/offsets
    for (int i = 0; i < 4; i++) begin
      drive_req(wv[i].port, 1'b1, wv[i].size, wv[i].addr, wv[i].wd);
      #2;
      check($sformatf("t4_%0d_addr_ok", i), {inst_addr_ok, data_addr_ok},
            wv[i].port ? 2'b01 : 2'b10);
      cyc(); inst_req = 0; data_req = 0; awready = 1; wready = 1;
      #2;
      check($sformatf("t4_%0d_strb", i), {awvalid, wvalid, wstrb}, {2'b11, wv[i].strb});
      check($sformatf("t4_%0d_aw", i), {awid, awsize, awaddr, wdata},
            {(wv[i].port ? 4'd1 : 4'd0), {1'b0, wv[i].size}, wv[i].addr, wv[i].wd});
      cyc(); awready = 0; wready = 0; bvalid = 1;
      #2;
      check($sformatf("t4_%0d_dok", i), {awvalid, wvalid, inst_data_ok, data_data_ok},
            {2'b00, ~wv[i].port, wv[i].port});
      cyc(); bvalid = 0;
      #2;
      check($sformatf("t4_%0d_idle", i), 32'(hs), 32'h0);
    end

    // 5: arready stall, other requests blocked
    drive_req(1'b1, 1'b0, 2'd1, 32'h8000_2002, 32'h0);
    #2;
    check("t5_grant", data_addr_ok, 1'b1);
    cyc();
    drive_req(1'b0, 1'b0, 2'd2, 32'h1FC0_0100, 32'h0);
    drive_req(1'b1, 1'b0, 2'd2, 32'h8000_3000, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("t5_wait%0d", i), {arvalid, inst_addr_ok, data_addr_ok, araddr},
            {3'b100, 32'h8000_2002});
      cyc();
    end
    arready = 1;
    #2;
    check("t5_ar_go", {arvalid, arsize, araddr}, {1'b1, 3'd1, 32'h8000_2002});
    cyc(); arready = 0; rvalid = 1; rdata = 32'h0000_7777;
    #2;
    check("t5_dok", {data_data_ok, inst_addr_ok, data_addr_ok}, 3'b100);
    cyc(); rvalid = 0; inst_req = 0; data_req = 0;
    #2;
    check("t5_idle", 32'(hs), 32'h0);

    // 6: async reset in RD_DATA, then normal operation
    drive_req(1'b0, 1'b0, 2'd2, 32'h1FC0_0000, 32'h0);
    cyc(); inst_req = 0; arready = 1;
    cyc(); arready = 0;
    #1;
    check("t6_in_rd_data", rready, 1'b1);
    resetn = 1'b0;
    #1;
    check("t6_async_clear", 32'(hs), 32'h0);
    cyc();
    check("t6_held", 32'(hs), 32'h0);
    resetn = 1'b1;
    cyc();
    drive_req(1'b1, 1'b0, 2'd2, 32'h8000_4000, 32'h0);
    #2;
    check("t6_post_grant", {data_addr_ok, inst_addr_ok}, 2'b10);
    cyc(); data_req = 0; arready = 1;
    #2;
    check("t6_post_ar", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h8000_4000});
    cyc(); arready = 0; rvalid = 1; rdata = 32'h0BAD_CAFE;
    #2;
    check("t6_post_dok", {data_data_ok, data_rdata}, {1'b1, 32'h0BAD_CAFE});
    cyc(); rvalid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_axi_bridge.md
# sram_like_axi_bridge

- Responder (slave) end of the sram-like protocol; turns CPU-side sram-like requests into AXI3 master transactions.
- Two sram-like slave ports:
  - inst: driven by the instruction-side sram-to-sram-like adapter.
  - data: driven by the data-side adapter.
- One AXI master port toward the SoC crossbar.
- Non-pipelined: at most one transaction in flight across both ports.

## Interface
Parameters:
- none (AXI fixed at 32-bit address/data, 4-bit ID)

Ports:
- clk  in  1  single clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req / inst_wr  in  1 / 1  instruction request, write flag
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr / inst_wdata  in  32 / 32  request address, write data
- inst_addr_ok / inst_data_ok  out  1 / 1  request accepted / transaction complete
- inst_rdata  out  32  read data, valid with inst_data_ok
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same widths and meaning as the inst_* ports
- arid, araddr, arsize, arvalid  out  4, 32, 3, 1;  arready  in  1
- rid, rdata, rresp, rlast, rvalid  in  4, 32, 2, 1, 1;  rready  out  1
- awid, awaddr, awsize, awvalid  out  4, 32, 3, 1;  awready  in  1
- wid, wdata, wstrb, wlast, wvalid  out  4, 32, 4, 1, 1;  wready  in  1
- bid, bresp, bvalid  in  4, 2, 1;  bready  out  1
- arlen, awlen  out  8  constant 0
- arburst, awburst  out  2  constant 2'b01
- arlock, awlock  out  2  constant 0
- arcache, awcache, arprot, awprot  out  4/3  constant 0

## Operation
States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.

- **IDLE**
  - Grant rule: data_req wins over inst_req.
  - The granted port's addr_ok is asserted combinationally in the same cycle as its req. The other port's addr_ok stays 0.
  - On grant, latch port id (inst=0, data=1), wr, size, addr, wdata.
  - Next state: wr=0 → RD_ADDR; wr=1 → WR_ADDR.
- **RD_ADDR**
  - arvalid=1; araddr/arsize/arid come from the latch.
  - arsize = {1'b0, size}.
  - On arready → RD_DATA.
- **RD_DATA**
  - rready=1.
  - On rvalid: pulse data_ok on the latched port and pass rdata through combinationally to that port's rdata; next state IDLE.
  - rresp is ignored.
- **WR_ADDR**
  - awvalid and wvalid both rise on entry. Each drops independently after its own handshake, tracked by two done flags.
  - When both handshakes are done (same cycle or different cycles) → WR_RESP.
  - wlast=1.
  - wstrb by size:
    - size 0: 4'b0001 << addr[1:0]
    - size 1: addr[1] ? 4'b1100 : 4'b0011
    - size 2: 4'b1111
  - wdata is the latched wdata, unshifted.
- **WR_RESP**
  - bready=1.
  - On bvalid: pulse data_ok on the latched port; next state IDLE.
- **Concurrency rules**
  - addr_ok and data_ok are never asserted together, because data_ok only occurs in RD_DATA/WR_RESP.
  - A req that arrives while not in IDLE gets addr_ok=0 and must be held by the master.
  - inst_rdata/data_rdata outside data_ok: the rdata bus is driven as-is; the value has no meaning.

## Timing
- **Reset** (async assert, synchronous-clean deassert):
  - State → IDLE; done flags cleared; latches cleared to 0.
  - All valid/ready outputs 0; all addr_ok/data_ok 0.
  - A reset mid-transaction abandons the AXI transaction. The slave must be reset too.
- **Minimum latencies**
  - Read: req/addr_ok at cycle 0; arvalid at cycle 1; with arready at 1 and rvalid at 2, data_ok at cycle 2.
  - Write: req/addr_ok at cycle 0; aw/w at cycle 1; with both readies at 1 and bvalid at 2, data_ok at cycle 2.
- **Back-to-back**: the next addr_ok can come at the cycle after data_ok, not the same cycle.
- **Stall behaviour**: AXI valids stay high and address/data stay stable until the matching ready.

## Structure
- Shared package (shared with the sram-like adapters), holding:
  - state encoding constants
  - SIZE_BYTE/HALF/WORD codes
  - AXI burst/ID constants: ID_INST=0, ID_DATA=1
- Natural sub-module: sram_like_arbiter.
  - Fixed-priority grant plus request latch.
  - Outputs: addr_ok per port and the latched request.
  - The bridge FSM consumes the latched request.

## Test plan
1. inst_req read of 0xBFC00000 with arready and rvalid the cycle after valid, rdata=0x3C080001 → inst_addr_ok at cycle 0, arvalid at cycle 1, inst_data_ok with inst_rdata=0x3C080001 at cycle 2, arid=0.
2. inst_req and data_req in the same cycle (data read 0x80001000) → data_addr_ok=1 and inst_addr_ok=0. The inst request is granted in the cycle after data_data_ok.
3. data write, size 0, addr 0x80000003, wdata 0xAB000000 → awsize=0, wstrb=4'b1000. awready at cycle 1, wready at cycle 3, bvalid at cycle 5 → data_data_ok at cycle 5 only.
4. Half-word write to 0x80000002 → wstrb=4'b1100. Word write → wstrb=4'b1111, awsize=2.
5. arready held low 10 cycles → araddr stable and arvalid high throughout; no addr_ok on either port during the wait.
6. resetn asserted in RD_DATA → outputs cleared asynchronously, state IDLE. A request after deassert is accepted normally.
